// File: rtl/pwl_tanh_post.sv
// pwl_tanh_post: tanh PWL output stage -- aligns x with the coefficient BRAM, computes round(a*x)+b,
// clamps to [-1,+1] and buffers results in a credit-guarded first-word fall-through FIFO.
module pwl_tanh_post #(
    parameter int W          = 32,
    parameter int FRAC       = 24,
    parameter int BRAM_LAT   = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x_in,
    output logic             bram_en,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     y_out,
    output logic             y_sat,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_count
);
    localparam int PW = 2 * W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [PW-1:0] HALF    = PW'(1) << (FRAC - 1);
    localparam logic signed [PW-1:0] HALF_M1 = HALF - PW'(1);
    localparam logic signed [PW-1:0] ONE     = PW'(1) << FRAC;
    localparam logic signed [PW-1:0] NEG_ONE = -ONE;

    logic [BRAM_LAT-1:0]  dv_q, dv_d;
    logic [W-1:0]         dx_q [BRAM_LAT];
    logic [W-1:0]         dx_d [BRAM_LAT];
    logic                 s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [W-1:0]         s1_x_q, s1_x_d, s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_b_q, s2_b_d;
    logic signed [PW-1:0] s2_p_q, s2_p_d;
    logic [W:0]           mem_q [FIFO_DEPTH];
    logic [W:0]           mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]     sc_q, sc_d;
    logic signed [PW-1:0] rnd, rs, s;
    logic                 gt, lt, sat, pop;
    logic [W-1:0]         y;
    int unsigned          used;

    always_comb begin
        // Every sample still in the pipe already owns a FIFO slot, so the pipe never stalls.
        used = 32'(cnt_q) + 32'(s1_v_q) + 32'(s2_v_q);
        for (int i = 0; i < BRAM_LAT; i++) used = used + 32'(dv_q[i]);
        in_ready = rst_n & (used < 32'(FIFO_DEPTH));
        bram_en  = in_valid & in_ready;
        dv_d[0] = bram_en;
        dx_d[0] = x_in;
        for (int i = 1; i < BRAM_LAT; i++) begin
            dv_d[i] = dv_q[i-1];
            dx_d[i] = dx_q[i-1];
        end
        s1_v_d = dv_q[BRAM_LAT-1];
        s1_x_d = dx_q[BRAM_LAT-1];
        s1_a_d = a_in;
        s1_b_d = b_in;
        s2_v_d = s1_v_q;
        s2_p_d = $signed(s1_a_q) * $signed(s1_x_q);
        s2_b_d = s1_b_q;
        // Round half away from zero, then add b at full width so the sum cannot wrap.
        rnd = s2_p_q + (s2_p_q[PW-1] ? HALF_M1 : HALF);
        rs  = rnd >>> FRAC;
        s   = rs + PW'($signed(s2_b_q));
        gt  = s > ONE;
        lt  = s < NEG_ONE;
        sat = gt | lt;
        y   = gt ? W'(ONE) : lt ? W'(NEG_ONE) : s[W-1:0];
        out_valid = cnt_q != '0;
        pop = out_valid & out_ready;
        for (int i = 0; i < FIFO_DEPTH; i++)
            mem_d[i] = (s2_v_q && wp_q == AW'(i)) ? {sat, y} : mem_q[i];
        wp_d  = wp_q + AW'(s2_v_q);
        rp_d  = rp_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(s2_v_q) - (AW+1)'(pop);
        sc_d  = sat_clr ? '0 : (s2_v_q && sat && !(&sc_q)) ? sc_q + CNT_W'(1) : sc_q;
        {y_sat, y_out} = out_valid ? mem_q[rp_q] : '0;
        sat_count = sc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q   <= '0;
            for (int i = 0; i < BRAM_LAT; i++) dx_q[i] <= '0;
            s1_v_q <= 1'b0;
            s1_x_q <= '0;
            s1_a_q <= '0;
            s1_b_q <= '0;
            s2_v_q <= 1'b0;
            s2_p_q <= '0;
            s2_b_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            sc_q   <= '0;
        end else begin
            dv_q   <= dv_d;
            dx_q   <= dx_d;
            s1_v_q <= s1_v_d;
            s1_x_q <= s1_x_d;
            s1_a_q <= s1_a_d;
            s1_b_q <= s1_b_d;
            s2_v_q <= s2_v_d;
            s2_p_q <= s2_p_d;
            s2_b_q <= s2_b_d;
            mem_q  <= mem_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            sc_q   <= sc_d;
        end
    end
endmodule

// File: tb/tb_pwl_tanh_post.sv
// tb_pwl_tanh_post: directed vector table plus hand-written sequences for latency, backpressure,
// reset flush and saturation counter; a queue scoreboard checks every popped result.
module tb_pwl_tanh_post;
    typedef struct packed { logic [31:0] y; logic s; } res_t;
    typedef struct { logic [31:0] x, a, b, y; logic s; } vec_t;

    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, sat_clr = 0;
    logic [31:0] x_in = 0, a_in = 0, b_in = 0;
    logic        in_ready, bram_en, out_valid, y_sat;
    logic [31:0] y_out;
    logic [15:0] sat_count;
    int          checks = 0, failures = 0, n_pop = 0, n_push = 0;
    res_t        exp_q [$];

    pwl_tanh_post dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .bram_en(bram_en), .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .y_out(y_out), .y_sat(y_sat), .sat_clr(sat_clr), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] x, input logic [31:0] a, input logic [31:0] b);
        longint p, m, r, s;
        p = longint'($signed(a)) * longint'($signed(x));
        m = p < 0 ? -p : p;
        r = (m + 64'sd8388608) >>> 24;
        if (p < 0) r = -r;
        s = r + longint'($signed(b));
        if (s > 64'sd16777216) return '{32'h01000000, 1'b1};
        if (s < -64'sd16777216) return '{32'hFF000000, 1'b1};
        return '{s[31:0], 1'b0};
    endfunction

    // One clock: present a sample; on acceptance the BRAM answers a/b one cycle later.
    task automatic step(input logic v, input logic [31:0] x, input logic [31:0] a,
                        input logic [31:0] b, input res_t e, output logic acc);
        in_valid = v;
        x_in = x;
        @(negedge clk);
        acc = bram_en;
        @(posedge clk);
        #1;
        if (acc) begin
            a_in = a;
            b_in = b;
            exp_q.push_back(e);
            n_push++;
        end
        in_valid = 0;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] a, input logic [31:0] b, input res_t e);
        logic acc;
        acc = 0;
        for (int i = 0; i < 64 && !acc; i++) step(1, x, a, b, e, acc);
        chk("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic idle();
        logic acc;
        step(0, 0, 0, 0, '0, acc);
    endtask

    task automatic drain();
        out_ready = 1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) idle();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got y=%h sat=%b with empty scoreboard", y_out, y_sat);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("out_data", 64'({y_out, y_sat}), 64'(e));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vt [12];
        logic        acc;
        int          lat, n_acc, n_clamp;
        logic [31:0] x, a, b;
        vt[0]  = '{32'h04000000, 32'h00800000, 32'h00800000, 32'h01000000, 1'b1};
        vt[1]  = '{32'hFC000000, 32'h00800000, 32'hFF800000, 32'hFF000000, 1'b1};
        vt[2]  = '{32'h00800000, 32'h00000001, 32'h00000000, 32'h00000001, 1'b0};
        vt[3]  = '{32'hFF800000, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vt[4]  = '{32'h007FFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0};
        vt[5]  = '{32'h01000000, 32'h01000000, 32'h00000000, 32'h01000000, 1'b0};
        vt[6]  = '{32'h01000000, 32'h01000000, 32'h00000001, 32'h01000000, 1'b1};
        vt[7]  = '{32'hFF000000, 32'h01000000, 32'h00000000, 32'hFF000000, 1'b0};
        vt[8]  = '{32'hFF000000, 32'h01000000, 32'hFFFFFFFF, 32'hFF000000, 1'b1};
        vt[9]  = '{32'h80000000, 32'h80000000, 32'h00000000, 32'h01000000, 1'b1};
        vt[10] = '{32'hFF800000, 32'h00C00000, 32'h00200000, 32'hFFC00000, 1'b0};
        vt[11] = '{32'hFF800001, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0};

        in_valid = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_bram_en", 64'(bram_en), 64'd0);
        chk("rst_out", 64'({out_valid, y_sat, y_out}), 64'd0);
        chk("rst_sat_count", 64'(sat_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        in_valid = 0;
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Nominal sample and its latency with the FIFO empty.
        out_ready = 0;
        step(1, 32'h00800000, 32'h00C00000, 32'h00200000, '{32'h00800000, 1'b0}, acc);
        chk("nominal_accept", 64'(acc), 64'd1);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk("nominal_latency", 64'(lat), 64'd4);
        chk("nominal_head", 64'({y_out, y_sat}), 64'({32'h00800000, 1'b0}));
        drain();

        n_clamp = 0;
        out_ready = 1;
        for (int i = 0; i < 12; i++) begin
            send(vt[i].x, vt[i].a, vt[i].b, '{vt[i].y, vt[i].s});
            n_clamp += int'(vt[i].s);
            if (i == 1) begin
                drain();
                chk("sat_count_two", 64'(sat_count), 64'd2);
            end
        end
        drain();
        chk("sat_count_table", 64'(sat_count), 64'(n_clamp));

        // Backpressure: only FIFO_DEPTH samples may be accepted.
        out_ready = 0;
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            x = $urandom();
            a = 32'($signed($urandom()) >>> 6);
            b = 32'($signed($urandom()) >>> 6);
            step(1, x, a, b, model(x, a, b), acc);
            n_acc += int'(acc);
        end
        chk("bp_accepted", 64'(n_acc), 64'd8);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        drain();
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);

        for (int k = 0; k < 1000; k++) begin
            x = 32'($signed($urandom()) >>> $urandom_range(0, 8));
            a = 32'($signed($urandom()) >>> 6);
            b = 32'($signed($urandom()) >>> 6);
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'($urandom_range(0, 1));
                idle();
            end
            acc = 0;
            for (int i = 0; i < 64 && !acc; i++) begin
                out_ready = 1'($urandom_range(0, 1));
                step(1, x, a, b, model(x, a, b), acc);
            end
            chk("rand_accept", 64'(acc), 64'd1);
        end
        drain();
        chk("push_pop_balance", 64'(n_pop), 64'(n_push));

        sat_clr = 1;
        idle();
        sat_clr = 0;
        chk("sat_clr_alone", 64'(sat_count), 64'd0);

        // Reset with five samples split between pipeline and FIFO.
        out_ready = 0;
        send(vt[0].x, vt[0].a, vt[0].b, '{vt[0].y, vt[0].s});
        send(vt[1].x, vt[1].a, vt[1].b, '{vt[1].y, vt[1].s});
        for (int i = 2; i < 5; i++) send(vt[i].x, vt[i].a, vt[i].b, '{vt[i].y, vt[i].s});
        chk("pre_rst_sat_count", 64'(sat_count), 64'd2);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        in_valid = 1;
        rst_n = 0;
        #1;
        chk("mid_rst_out", 64'({out_valid, y_sat, y_out}), 64'd0);
        chk("mid_rst_sat_count", 64'(sat_count), 64'd0);
        chk("mid_rst_bram_en", 64'(bram_en), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        in_valid = 0;
        out_ready = 1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        send(vt[10].x, vt[10].a, vt[10].b, '{vt[10].y, vt[10].s});
        drain();

        // Saturation counter: pin at all-ones, then clear coincident with a clamped write.
        out_ready = 1;
        for (int i = 0; i < 65540; i++) send(vt[0].x, vt[0].a, vt[0].b, '{vt[0].y, vt[0].s});
        drain();
        chk("sat_count_full", 64'(sat_count), 64'hFFFF);
        send(vt[1].x, vt[1].a, vt[1].b, '{vt[1].y, vt[1].s});
        drain();
        chk("sat_count_hold", 64'(sat_count), 64'hFFFF);
        out_ready = 0;
        send(vt[0].x, vt[0].a, vt[0].b, '{vt[0].y, vt[0].s});
        idle();
        idle();
        chk("clr_pre_write", 64'(out_valid), 64'd0);
        sat_clr = 1;
        idle();
        sat_clr = 0;
        chk("clr_write_done", 64'(out_valid), 64'd1);
        chk("clr_wins", 64'(sat_count), 64'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
